// File: rtl/cflog_writer.sv
// Control-flow log writer: buffers (src,dst) branch pairs in a small FIFO and streams them
// as two 16-bit words into the CFLog region, stalling at log_full until the TCB flushes.
module cflog_writer #(
  parameter logic [15:0] LOG_BASE   = 16'hE000,
  parameter int unsigned LOG_SIZE   = 16'h0100,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_detect,
  input  logic [15:0] br_src,
  input  logic [15:0] br_dst,
  input  logic        tcb_active,
  input  logic        flush_done,
  output logic        mem_wr_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic [15:0] log_ptr,
  output logic        log_full,
  output logic        overflow,
  output logic [2:0]  fifo_level
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW     = PtrW + 1;
  localparam logic [15:0] LogSizeW = 16'(LOG_SIZE);
  localparam logic [LvlW-1:0] DepthL = LvlW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWrSrc, StWrDst, StFull} state_e;

  state_e state_q, state_d;

  logic [15:0]     src_mem_q [FIFO_DEPTH];
  logic [15:0]     dst_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            fifo_full, fifo_empty, push, drop, pop;

  logic        mem_wr_en_q, mem_wr_en_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [15:0] log_ptr_q, log_ptr_d, ptr_inc;
  logic        log_full_q, log_full_d, overflow_q, overflow_d;
  logic        flush_pend_q, flush_pend_d, ovf_clr, flush_now;

  assign fifo_full  = (level_q == DepthL);
  assign fifo_empty = (level_q == '0);
  assign push       = branch_detect & ~tcb_active & ~fifo_full;
  assign drop       = branch_detect & ~tcb_active & fifo_full;
  assign ptr_inc    = log_ptr_q + 16'd1;
  assign flush_now  = flush_pend_q | flush_done;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q + LvlW'(push) - LvlW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      src_mem_q[wr_ptr_q] <= br_src;
      dst_mem_q[wr_ptr_q] <= br_dst;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!flush_now && !fifo_empty && !log_full_q) state_d = StWrSrc;
      StWrSrc: if (mem_ack) state_d = StWrDst;
      StWrDst: if (mem_ack) state_d = (ptr_inc == LogSizeW) ? StFull : StIdle;
      StFull:  if (flush_now) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values; write requests hold until acked
  always_comb begin
    mem_wr_en_d  = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    log_ptr_d    = log_ptr_q;
    log_full_d   = log_full_q;
    flush_pend_d = flush_pend_q;
    ovf_clr      = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_now) begin
          log_ptr_d    = '0;
          log_full_d   = 1'b0;
          flush_pend_d = 1'b0;
          ovf_clr      = 1'b1;
        end else if (!fifo_empty && !log_full_q) begin
          mem_wr_en_d = 1'b1;
          mem_addr_d  = LOG_BASE + {log_ptr_q[14:0], 1'b0};
          mem_wdata_d = src_mem_q[rd_ptr_q];
        end
      end
      StWrSrc: begin
        if (flush_done) flush_pend_d = 1'b1;
        mem_wr_en_d = 1'b1;
        if (mem_ack) begin
          log_ptr_d   = ptr_inc;
          mem_addr_d  = LOG_BASE + {ptr_inc[14:0], 1'b0};
          mem_wdata_d = dst_mem_q[rd_ptr_q];
        end else begin
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      StWrDst: begin
        if (flush_done) flush_pend_d = 1'b1;
        if (mem_ack) begin
          pop       = 1'b1;
          log_ptr_d = ptr_inc;
          if (ptr_inc == LogSizeW) log_full_d = 1'b1;
        end else begin
          mem_wr_en_d = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      StFull: begin
        if (flush_now) begin
          log_ptr_d    = '0;
          log_full_d   = 1'b0;
          flush_pend_d = 1'b0;
          ovf_clr      = 1'b1;
        end
      end
      default: ;
    endcase
    // A drop in the same cycle as a clear keeps overflow set
    overflow_d = drop | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      log_ptr_q    <= '0;
      log_full_q   <= 1'b0;
      overflow_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      log_ptr_q    <= log_ptr_d;
      log_full_q   <= log_full_d;
      overflow_q   <= overflow_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign log_ptr    = log_ptr_q;
  assign log_full   = log_full_q;
  assign overflow   = overflow_q;
  assign fifo_level = 3'(level_q);

endmodule

// File: tb/tb_cflog_writer.sv
// Bench for cflog_writer: directed scenarios plus random traffic, checked against a
// transaction-level model (pending-pair queue, word stream, log pointer, sticky overflow).
module tb_cflog_writer;

  localparam logic [15:0] LogBase   = 16'hE000;
  localparam int unsigned LogSize   = 4;
  localparam int unsigned FifoDepth = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_detect = 1'b0, tcb_active = 1'b0, flush_done = 1'b0, mem_ack = 1'b0;
  logic [15:0] br_src = '0, br_dst = '0;
  logic        mem_wr_en, log_full, overflow;
  logic [15:0] mem_addr, mem_wdata, log_ptr;
  logic [2:0]  fifo_level;

  cflog_writer #(.LOG_BASE(LogBase), .LOG_SIZE(LogSize), .FIFO_DEPTH(FifoDepth)) dut (
    .clk(clk), .reset(reset), .branch_detect(branch_detect), .br_src(br_src),
    .br_dst(br_dst), .tcb_active(tcb_active), .flush_done(flush_done),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .log_ptr(log_ptr), .log_full(log_full), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [15:0] m_qs[$], m_qd[$];
  int          m_ptr;
  bit          m_full, m_ovf, m_half, m_en;
  bit          prev_stall, after_rst;
  logic [15:0] prev_addr, prev_data;
  logic [15:0] obs_addr[$], obs_data[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at the falling edge
  task automatic cyc(input logic bd, input logic [15:0] s, input logic [15:0] d,
                     input logic tcb, input logic fd, input logic ack, input logic rst);
    bit full_before;
    if (m_en) begin
      check_eq("log_ptr", 32'(log_ptr), 32'(m_ptr));
      check_eq("log_full", 32'(log_full), 32'(m_full));
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      check_eq("fifo_level", 32'(fifo_level), 32'(m_qs.size()));
      if (mem_wr_en && (m_full || m_qs.size() == 0)) check_eq("wr_gate", 32'(mem_wr_en), 0);
    end
    if (prev_stall) begin
      check_eq("hold_en", 32'(mem_wr_en), 1);
      check_eq("hold_addr", 32'(mem_addr), 32'(prev_addr));
      check_eq("hold_data", 32'(mem_wdata), 32'(prev_data));
    end
    if (after_rst) begin
      check_eq("rst_wr_en", 32'(mem_wr_en), 0);
      check_eq("rst_addr", 32'(mem_addr), 0);
      check_eq("rst_wdata", 32'(mem_wdata), 0);
    end
    branch_detect = bd; br_src = s; br_dst = d; tcb_active = tcb;
    flush_done = fd; mem_ack = ack; reset = rst;
    if (mem_wr_en && ack && !rst) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
    end
    if (rst) begin
      m_qs.delete(); m_qd.delete();
      m_ptr = 0; m_full = 0; m_ovf = 0; m_half = 0;
    end else if (m_en) begin
      bit do_pop, ovf_set, ovf_clr;
      full_before = m_full;
      do_pop = 0;
      if (mem_wr_en && ack) begin
        if (m_qs.size() == 0) begin
          check_eq("wr_unexpected", 32'(mem_wr_en), 0);
        end else begin
          check_eq("wr_addr", 32'(mem_addr), 32'(16'(LogBase + 16'(2 * m_ptr))));
          check_eq("wr_data", 32'(mem_wdata), 32'(m_half ? m_qd[0] : m_qs[0]));
        end
        m_ptr++;
        if (m_half) begin
          do_pop = 1; m_half = 0;
          if (m_ptr == LogSize) m_full = 1;
        end else m_half = 1;
      end
      ovf_set = 0;
      if (bd && !tcb) begin
        if (m_qs.size() < FifoDepth) begin
          m_qs.push_back(s); m_qd.push_back(d);
        end else ovf_set = 1;
      end
      if (do_pop) begin
        void'(m_qs.pop_front()); void'(m_qd.pop_front());
      end
      ovf_clr = fd && full_before;
      if (ovf_clr) begin m_ptr = 0; m_full = 0; end
      m_ovf = ovf_set | (m_ovf & ~ovf_clr);
    end
    prev_stall = mem_wr_en && !ack && !rst;
    prev_addr  = mem_addr;
    prev_data  = mem_wdata;
    after_rst  = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ack, input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, 0, ack, 0);
  endtask

  task automatic do_reset();
    cyc(0, '0, '0, 0, 0, 0, 1);
    obs_addr.delete(); obs_data.delete();
  endtask

  logic [15:0] t_src[6], t_dst[6];

  initial begin
    m_en = 0; prev_stall = 0; after_rst = 0;
    m_ptr = 0; m_full = 0; m_ovf = 0; m_half = 0;
    @(negedge clk);
    do_reset();
    m_en = 1;
    check_eq("reset_ptr", 32'(log_ptr), 0);
    check_eq("reset_level", 32'(fifo_level), 0);

    // Single pair, ack tied high, minimum latency
    cyc(1, 16'h4010, 16'h4200, 0, 0, 1, 0);
    check_eq("t1_lat1", 32'(mem_wr_en), 0);
    cyc(0, '0, '0, 0, 0, 1, 0);
    check_eq("t1_lat2", 32'(mem_wr_en), 1);
    check_eq("t1_addr0", 32'(mem_addr), 32'h0000E000);
    check_eq("t1_data0", 32'(mem_wdata), 32'h00004010);
    cyc(0, '0, '0, 0, 0, 1, 0);
    check_eq("t1_addr1", 32'(mem_addr), 32'h0000E002);
    check_eq("t1_data1", 32'(mem_wdata), 32'h00004200);
    cyc(0, '0, '0, 0, 0, 1, 0);
    check_eq("t1_ptr", 32'(log_ptr), 2);
    check_eq("t1_level", 32'(fifo_level), 0);

    // Long stall in WR_SRC
    cyc(1, 16'h1234, 16'h5678, 0, 0, 0, 0);
    idle(0, 1);
    check_eq("t2_addr", 32'(mem_addr), 32'h0000E004);
    idle(0, 5);
    check_eq("t2_ptr_stall", 32'(log_ptr), 2);
    idle(1, 1);
    check_eq("t2_ptr_inc", 32'(log_ptr), 3);
    idle(1, 1);
    check_eq("t2_full", 32'(log_full), 1);
    cyc(0, '0, '0, 0, 1, 0, 0);
    check_eq("t2_flush_ptr", 32'(log_ptr), 0);

    // FIFO overflow then in-order drain across a flush
    do_reset();
    for (int i = 0; i < 6; i++) begin
      t_src[i] = 16'($urandom); t_dst[i] = 16'($urandom);
      cyc(1, t_src[i], t_dst[i], 0, 0, 0, 0);
    end
    check_eq("t3_level", 32'(fifo_level), 4);
    check_eq("t3_ovf", 32'(overflow), 1);
    for (int i = 0; i < 80 && obs_data.size() < 8; i++) cyc(0, '0, '0, 0, m_full, 1, 0);
    check_eq("t3_words", 32'(obs_data.size()), 8);
    for (int i = 0; i < 4 && 2 * i + 1 < obs_data.size(); i++) begin
      check_eq("t3_src", 32'(obs_data[2*i]), 32'(t_src[i]));
      check_eq("t3_dst", 32'(obs_data[2*i+1]), 32'(t_dst[i]));
    end

    // Log fills with a pair still pending
    do_reset();
    for (int i = 0; i < 3; i++) begin
      t_src[i] = 16'($urandom); t_dst[i] = 16'($urandom);
      cyc(1, t_src[i], t_dst[i], 0, 0, 1, 0);
    end
    idle(1, 12);
    check_eq("t4_full", 32'(log_full), 1);
    check_eq("t4_ptr", 32'(log_ptr), 4);
    check_eq("t4_level", 32'(fifo_level), 1);
    obs_addr.delete(); obs_data.delete();
    cyc(0, '0, '0, 0, 1, 1, 0);
    check_eq("t4_flush_ptr", 32'(log_ptr), 0);
    check_eq("t4_flush_ovf", 32'(overflow), 0);
    idle(1, 6);
    check_eq("t4_n", 32'(obs_addr.size()), 2);
    if (obs_addr.size() > 0) begin
      check_eq("t4_addr", 32'(obs_addr[0]), 32'h0000E000);
      check_eq("t4_data", 32'(obs_data[0]), 32'(t_src[2]));
    end

    // TCB active suppresses capture
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 16'($urandom), 16'($urandom), 1, 0, 1, 0);
    check_eq("t5_level", 32'(fifo_level), 0);
    check_eq("t5_ovf", 32'(overflow), 0);

    // Flush arriving mid-pair, then reset mid-WR_DST
    do_reset();
    cyc(1, 16'h0101, 16'h0202, 0, 0, 1, 0);
    idle(1, 4);
    check_eq("t6_ptr2", 32'(log_ptr), 2);
    cyc(1, 16'hAAAA, 16'hBBBB, 0, 0, 0, 0);
    m_en = 0;
    for (int i = 0; i < 10 && !mem_wr_en; i++) idle(0, 1);
    check_eq("t6_wait", 32'(mem_wr_en), 1);
    cyc(0, '0, '0, 0, 1, 0, 0);
    obs_addr.delete(); obs_data.delete();
    idle(1, 6);
    check_eq("t6_n", 32'(obs_addr.size()), 2);
    if (obs_addr.size() == 2) begin
      check_eq("t6_addr0", 32'(obs_addr[0]), 32'h0000E004);
      check_eq("t6_data0", 32'(obs_data[0]), 32'h0000AAAA);
      check_eq("t6_addr1", 32'(obs_addr[1]), 32'h0000E006);
      check_eq("t6_data1", 32'(obs_data[1]), 32'h0000BBBB);
    end
    check_eq("t6_ptr0", 32'(log_ptr), 0);
    check_eq("t6_full0", 32'(log_full), 0);
    cyc(1, 16'h1111, 16'h2222, 0, 0, 0, 0);
    for (int i = 0; i < 10 && !mem_wr_en; i++) idle(0, 1);
    idle(1, 1);
    check_eq("t6_in_dst", 32'(mem_wdata), 32'h00002222);
    cyc(0, '0, '0, 0, 0, 0, 1);
    check_eq("t6_rst_en", 32'(mem_wr_en), 0);
    check_eq("t6_rst_ptr", 32'(log_ptr), 0);
    check_eq("t6_rst_level", 32'(fifo_level), 0);
    check_eq("t6_rst_full", 32'(log_full), 0);
    check_eq("t6_rst_ovf", 32'(overflow), 0);
    m_en = 1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic bd, tcb, fd, ack, rst;
      bd  = ($urandom_range(0, 99) < 40);
      tcb = ($urandom_range(0, 99) < 10);
      ack = ($urandom_range(0, 99) < 60);
      fd  = m_full && ($urandom_range(0, 99) < 20);
      rst = ($urandom_range(0, 199) == 0);
      cyc(bd, 16'($urandom), 16'($urandom), tcb, fd, ack, rst);
    end
    idle(0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cflog_writer.md
Name: cflog_writer

Overview:
- Sequences control-flow log writes for the CFA hardware.
- On each `branch_detect` pulse it captures the (source, destination) PC pair into a small pending FIFO.
- It drains the FIFO into the TCB-protected CFLog region over a single-word write handshake and maintains the log pointer.
- It raises `log_full` so the top level can assert `acfa_nmi` and enter the TCB, then resumes after the TCB signals `flush_done`.

Parameters:
- LOG_BASE, 16'hE000, byte base address of the CFLog region.
- LOG_SIZE, 16'h0100, log capacity in 16-bit words; must be even and nonzero.
- FIFO_DEPTH, 4, pending (src,dst) pair entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- branch_detect  in  1  one-cycle branch event from the branch monitor.
- br_src  in  16  PC of the branching instruction; valid with branch_detect.
- br_dst  in  16  branch target PC; valid with branch_detect.
- tcb_active  in  1  TCB executing; suppresses capture.
- flush_done  in  1  one-cycle pulse: TCB has consumed the log.
- mem_wr_en  out  1  log write request.
- mem_addr  out  16  byte address of the write.
- mem_wdata  out  16  write data.
- mem_ack  in  1  write accepted in this cycle; valid only while mem_wr_en=1.
- log_ptr  out  16  words written since the last flush.
- log_full  out  1  log reached LOG_SIZE.
- overflow  out  1  sticky: at least one event was dropped.
- fifo_level  out  3  pending pairs, 0..FIFO_DEPTH.

Behaviour:

Reset values:
- All outputs 0 and FIFO empty.
- FSM in IDLE and flush_pend=0.
- Reset mid-write abandons the write; no ack is expected afterwards.

Capture:
- Push {br_src, br_dst} when branch_detect=1 and tcb_active=0 and the FIFO is not full.
- If the FIFO is full, drop the event and set overflow=1.
- With tcb_active=1 the event is ignored and overflow is unchanged.
- Push and pop in the same cycle are allowed, and the level stays unchanged.
- A push into an empty FIFO is first visible to the FSM the next cycle, so minimum event-to-mem_wr_en latency is 2 cycles.

FSM states IDLE, WR_SRC, WR_DST, FULL:

- IDLE:
  - If flush_pend or flush_done: clear log_ptr, clear overflow, clear flush_pend, and stay in IDLE.
  - Else if the FIFO is non-empty and log_full=0: go to WR_SRC.
- WR_SRC:
  - mem_wr_en=1, mem_addr=LOG_BASE+(log_ptr<<1), mem_wdata=head.src.
  - On mem_ack: log_ptr+1, go to WR_DST.
- WR_DST:
  - mem_wr_en=1, mem_addr=LOG_BASE+(log_ptr<<1), mem_wdata=head.dst.
  - On mem_ack: pop the FIFO and log_ptr+1.
  - If the new log_ptr==LOG_SIZE, set log_full=1 and go to FULL; else go to IDLE.
- FULL:
  - mem_wr_en=0; capture continues into the FIFO.
  - On flush_done: log_ptr=0, log_full=0, overflow=0, go to IDLE.

Handshake rules:
- mem_wr_en, mem_addr and mem_wdata are registered.
- They are held stable until the cycle mem_ack=1; ack in the first request cycle is legal.
- mem_wr_en deasserts the cycle after the ack unless the next write follows immediately (WR_SRC→WR_DST is back-to-back).
- A pair is never split across a flush: flush_done arriving in WR_SRC or WR_DST sets flush_pend, which is applied in IDLE.

Arithmetic:
- Address arithmetic is 16-bit modulo.
- log_ptr never exceeds LOG_SIZE.
- fifo_level counts full pairs only.

Simultaneous events:
- branch_detect in the same cycle as flush_done: the event is captured and survives the flush.
- overflow set and cleared in the same cycle: set wins.

Test Plan:
1. Reset, then branch_detect with src=16'h4010, dst=16'h4200, mem_ack tied 1 → writes 16'h4010@16'hE000 then 16'h4200@16'hE002; log_ptr=2; fifo_level returns to 0.
2. mem_ack held low 5 cycles during WR_SRC → mem_addr/mem_wdata/mem_wr_en stable for all 6 cycles; exactly one log_ptr increment.
3. 6 branch events on consecutive cycles with mem_ack=0 → fifo_level=4, overflow=1; release ack → exactly 4 pairs (8 words) written in order.
4. LOG_SIZE=4, three events → log_full=1 after word 4 with log_ptr=4; third pair held (fifo_level=1); flush_done → log_ptr=0, overflow=0, third pair written at 16'hE000.
5. tcb_active=1 while branch_detect pulses → no push, fifo_level=0, overflow unchanged.
6. flush_done during WR_SRC with ptr=2 → pair completes at 16'hE004/16'hE006, then log_ptr=0 in IDLE; reset asserted mid-WR_DST → all outputs 0 next cycle.
